// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner: row rotation, column sync, press/release
// debounce, and a single-entry key holding register with valid/ack handshake.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
  localparam int CW = (DEBOUNCE_CNT < 1) ? 1 : $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state;
  logic [3:0]    col_m, col_s;
  logic [DW-1:0] div;
  logic [CW-1:0] deb_cnt, rel_cnt;
  logic [7:0]    cand;
  logic [7:0]    acc_code;
  logic [3:0]    row_next;
  logic          tick, single, accept;

  assign tick     = (div == DIV_LAST);
  assign row_next = {row_n[2:0], row_n[3]};
  // exactly one column pulled low; all-high and multi-low (ghost) both count as idle
  assign single   = (col_s == 4'b1110) || (col_s == 4'b1101) ||
                    (col_s == 4'b1011) || (col_s == 4'b0111);

  // two-flop synchroniser for the asynchronous column lines
  always_ff @(posedge clk) begin
    if (rst) begin
      col_m <= 4'b1111;
      col_s <= 4'b1111;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
    end
  end

  // accept fires on the sample that completes the press debounce
  always_comb begin
    accept   = 1'b0;
    acc_code = cand;
    if (tick) begin
      case (state)
        SCAN: begin
          if (single && DEBOUNCE_CNT == 1) begin
            accept   = 1'b1;
            acc_code = {row_n, col_s};
          end
        end
        DEBOUNCE: begin
          if (col_s == cand[3:0] && (deb_cnt + CNT_ONE) == CNT_LAST) accept = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // scan/debounce FSM plus holding register; every state change lands on a tick,
  // so wrapping the divider on tick also restarts it on row and state changes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      div       <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      cand      <= 8'hFF;
      row_n     <= 4'b1110;
      key_code  <= 8'hFF;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DIV_ONE;
      if (tick) begin
        case (state)
          SCAN: begin
            if (single) begin
              cand    <= {row_n, col_s};
              deb_cnt <= CNT_ONE;
              if (DEBOUNCE_CNT == 1) begin
                state    <= HELD;
                key_held <= 1'b1;
                rel_cnt  <= '0;
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              row_n <= row_next;
            end
          end
          DEBOUNCE: begin
            if (col_s == cand[3:0]) begin
              deb_cnt <= deb_cnt + CNT_ONE;
              if (accept) begin
                state    <= HELD;
                key_held <= 1'b1;
                rel_cnt  <= '0;
              end
            end else begin
              state   <= SCAN;
              row_n   <= row_next;
              deb_cnt <= '0;
            end
          end
          HELD: begin
            if (!single) begin
              if ((rel_cnt + CNT_ONE) == CNT_LAST) begin
                state    <= SCAN;
                key_held <= 1'b0;
                row_n    <= row_next;
                rel_cnt  <= '0;
              end else begin
                rel_cnt <= rel_cnt + CNT_ONE;
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
      // consumer handshake; a same-cycle accept below overrides the clear
      if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
      if (accept) begin
        if (!key_valid || key_ack) begin
          key_code  <= acc_code;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a two-key matrix model.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       overrun;

  // keypad model: a pressed key pulls its column low only while its row is driven
  logic       k0_on = 1'b0, k1_on = 1'b0;
  logic [3:0] k0_row = 4'hF, k0_col = 4'hF, k1_row = 4'hF, k1_col = 4'hF;
  assign col_n = ((k0_on && row_n == k0_row) ? k0_col : 4'hF) &
                 ((k1_on && row_n == k1_row) ? k1_col : 4'hF);

  int cmp = 0;
  int err = 0;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // leaves the bench at the start of cycle k=0 (first cycle out of reset)
  task automatic do_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] er;
    k0_on = 1'b0; k1_on = 1'b0;
    do_reset;
    @(negedge clk);
    cmp++; if (row_n !== 4'b1110) begin err++; $display("FAIL t1_row got=%b exp=1110", row_n); end
    cmp++; if (key_code !== 8'hFF) begin err++; $display("FAIL t1_code got=%h exp=ff", key_code); end
    cmp++; if (key_valid !== 1'b0) begin err++; $display("FAIL t1_valid got=%b exp=0", key_valid); end
    cmp++; if (key_held !== 1'b0) begin err++; $display("FAIL t1_held got=%b exp=0", key_held); end
    cmp++; if (overrun !== 1'b0) begin err++; $display("FAIL t1_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1;
    er = 4'b1101;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        cmp++; if (row_n !== er) begin err++; $display("FAIL t1_rotate k=%0d got=%b exp=%b", k, row_n, er); end
        er = {er[2:0], er[3]};
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_press_ack;
    int n;
    k0_row = 4'b1011; k0_col = 4'b1101; k0_on = 1'b1; k1_on = 1'b0;
    do_reset;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    cmp++; if (key_valid !== 1'b1) begin err++; $display("FAIL t2_valid_timeout got=%b exp=1", key_valid); end
    cmp++; if (key_code !== 8'hBD) begin err++; $display("FAIL t2_code got=%h exp=bd", key_code); end
    cmp++; if (key_held !== 1'b1) begin err++; $display("FAIL t2_held got=%b exp=1", key_held); end
    repeat (10) @(negedge clk);
    cmp++; if (key_valid !== 1'b1) begin err++; $display("FAIL t2_valid_level got=%b exp=1", key_valid); end
    cmp++; if (key_code !== 8'hBD) begin err++; $display("FAIL t2_code_stable got=%h exp=bd", key_code); end
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    cmp++; if (key_valid !== 1'b0) begin err++; $display("FAIL t2_ack_clear got=%b exp=0", key_valid); end
    k0_on = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    cmp++; if (key_held !== 1'b0) begin err++; $display("FAIL t2_release_timeout got=%b exp=0", key_held); end
  endtask

  task automatic test_bounce;
    logic bad;
    bad = 1'b0;
    k0_row = 4'b1110; k0_col = 4'b1101; k0_on = 1'b1; k1_on = 1'b0;
    do_reset;
    for (int k = 0; k < 64; k++) begin
      k0_on = ((k / 4) % 2) == 0;
      @(negedge clk);
      if (k == 4) begin
        cmp++; if (row_n !== 4'b1110) begin err++; $display("FAIL t3_frozen got=%b exp=1110", row_n); end
      end
      if (k == 8) begin
        cmp++; if (row_n !== 4'b1101) begin err++; $display("FAIL t3_resume got=%b exp=1101", row_n); end
      end
      if (key_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    cmp++; if (bad !== 1'b0) begin err++; $display("FAIL t3_no_valid got=%b exp=0", bad); end
    k0_on = 1'b0;
  endtask

  task automatic test_ghost;
    logic bad;
    int n;
    bad = 1'b0;
    k0_row = 4'b1110; k0_col = 4'b1001; k0_on = 1'b1; k1_on = 1'b0;
    do_reset;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 4) begin
        cmp++; if (row_n !== 4'b1101) begin err++; $display("FAIL t4_row_k4 got=%b exp=1101", row_n); end
      end
      if (k == 16) begin
        cmp++; if (row_n !== 4'b1110) begin err++; $display("FAIL t4_row_k16 got=%b exp=1110", row_n); end
      end
      if (k == 20) begin
        cmp++; if (row_n !== 4'b1101) begin err++; $display("FAIL t4_row_k20 got=%b exp=1101", row_n); end
      end
      if (key_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    cmp++; if (bad !== 1'b0) begin err++; $display("FAIL t4_no_valid got=%b exp=0", bad); end
    k0_row = 4'b0111; k0_col = 4'b0111;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    cmp++; if (key_valid !== 1'b1) begin err++; $display("FAIL t4_valid_timeout got=%b exp=1", key_valid); end
    cmp++; if (key_code !== 8'h77) begin err++; $display("FAIL t4_code got=%h exp=77", key_code); end
    k0_on = 1'b0;
  endtask

  task automatic test_overrun;
    int n;
    k0_row = 4'b1110; k0_col = 4'b1011; k0_on = 1'b1; k1_on = 1'b0;
    do_reset;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    cmp++; if (key_code !== 8'hEB) begin err++; $display("FAIL t5_first_code got=%h exp=eb", key_code); end
    k0_on = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    k0_row = 4'b0111; k0_col = 4'b1011; k0_on = 1'b1;
    n = 0;
    while (key_held !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    cmp++; if (key_held !== 1'b1) begin err++; $display("FAIL t5_second_timeout got=%b exp=1", key_held); end
    cmp++; if (key_code !== 8'hEB) begin err++; $display("FAIL t5_code_kept got=%h exp=eb", key_code); end
    cmp++; if (overrun !== 1'b1) begin err++; $display("FAIL t5_overrun got=%b exp=1", overrun); end
    cmp++; if (key_valid !== 1'b1) begin err++; $display("FAIL t5_valid got=%b exp=1", key_valid); end
    k0_on = 1'b0;
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    cmp++; if (key_valid !== 1'b0) begin err++; $display("FAIL t5_ack_valid got=%b exp=0", key_valid); end
    cmp++; if (overrun !== 1'b0) begin err++; $display("FAIL t5_ack_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back;
    k0_row = 4'b1110; k0_col = 4'b1110; k0_on = 1'b1;
    k1_row = 4'b1101; k1_col = 4'b1110; k1_on = 1'b0;
    do_reset;
    for (int k = 0; k <= 54; k++) begin
      if (k == 13) begin k0_on = 1'b0; k1_on = 1'b1; end
      if (k == 35) key_ack = 1'b1;
      if (k == 36) key_ack = 1'b0;
      if (k == 37) begin k1_on = 1'b0; k0_row = 4'b1011; k0_col = 4'b0111; k0_on = 1'b1; end
      if (k == 53) rst = 1'b1;
      if (k == 54) rst = 1'b0;
      @(negedge clk);
      if (k == 12) begin
        cmp++; if (key_code !== 8'hEE) begin err++; $display("FAIL t6_first_code got=%h exp=ee", key_code); end
        cmp++; if (key_held !== 1'b1) begin err++; $display("FAIL t6_first_held got=%b exp=1", key_held); end
      end
      if (k == 24) begin
        cmp++; if (key_held !== 1'b0) begin err++; $display("FAIL t6_release got=%b exp=0", key_held); end
        cmp++; if (row_n !== 4'b1101) begin err++; $display("FAIL t6_next_row got=%b exp=1101", row_n); end
      end
      if (k == 36) begin
        cmp++; if (key_valid !== 1'b1) begin err++; $display("FAIL t6_valid got=%b exp=1", key_valid); end
        cmp++; if (key_code !== 8'hDE) begin err++; $display("FAIL t6_code got=%h exp=de", key_code); end
        cmp++; if (overrun !== 1'b0) begin err++; $display("FAIL t6_overrun got=%b exp=0", overrun); end
      end
      if (k == 52) begin
        cmp++; if (row_n !== 4'b1011) begin err++; $display("FAIL t6_deb_row got=%b exp=1011", row_n); end
      end
      if (k == 54) begin
        cmp++; if (row_n !== 4'b1110) begin err++; $display("FAIL t6_rst_row got=%b exp=1110", row_n); end
        cmp++; if (key_valid !== 1'b0) begin err++; $display("FAIL t6_rst_valid got=%b exp=0", key_valid); end
        cmp++; if (key_code !== 8'hFF) begin err++; $display("FAIL t6_rst_code got=%h exp=ff", key_code); end
      end
      @(posedge clk); #1;
    end
    k0_on = 1'b0;
  endtask

  initial begin
    test_reset;
    test_press_ack;
    test_bounce;
    test_ghost;
    test_overrun;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
